dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data memory between the pipeline MEM stage and a loader/debug
//  requester (program load, memory dump). Pipeline has priority. A starvation FSM guarantees
//  the loader a slot within MAX_WAIT cycles by stalling the pipeline for one cycle.
//  Sits between the MEM stage (ALU result/write data/control) and data_mem.
// PARAMETERS
//  MAX_WAIT  4   cycles a pending loader request may be blocked before a forced grant (>=1)
//  CNT_W     16  width of forced-grant performance counter (saturating)
// PORTS
//  clk            in   1       system clock; all state updates on rising edge
//  reset          in   1       synchronous, active-high
//  p_read         in   1       MEM-stage load (MemRead)
//  p_write        in   1       MEM-stage store (MemWrite)
//  p_addr         in   `WORD   MEM-stage address (ALU result)
//  p_wdata        in   `WORD   MEM-stage store data
//  p_rdata        out  `WORD   load data to MEM/WB buffer (combinational)
//  stall          out  1       pipeline must hold its MEM access this cycle (combinational)
//  l_req          in   1       loader request; held until l_gnt
//  l_we           in   1       loader write(1)/read(0)
//  l_addr         in   `WORD   loader address
//  l_wdata        in   `WORD   loader write data
//  l_gnt          out  1       loader access performed this cycle (combinational)
//  l_rdata        out  `WORD   registered loader read data
//  l_valid        out  1       l_rdata valid (1-cycle pulse, cycle after a read grant)
//  mem_read       out  1       to data_mem read
//  mem_write      out  1       to data_mem write
//  mem_address    out  `WORD   to data_mem address
//  mem_write_data out  `WORD   to data_mem write_data
//  mem_read_data  in   `WORD   from data_mem read_data (asynchronous read)
//  forced_cnt     out  CNT_W   number of forced grants, saturates at all-ones
// BEHAVIOUR
//  - p_active = p_read | p_write. Both asserted together: forwarded unchanged.
//  - FSM states: S_IDLE, S_WAIT, S_FORCE. wait_cnt is $clog2(MAX_WAIT+1) bits.
//    S_IDLE:  l_req & !p_active -> grant now, stay S_IDLE.
//             l_req & p_active -> S_WAIT, wait_cnt=1. Otherwise stay.
//    S_WAIT:  !l_req -> S_IDLE, cnt=0, no grant.
//             l_req & !p_active -> grant, S_IDLE, cnt=0.
//             l_req & p_active & cnt==MAX_WAIT-1 -> S_FORCE. Else cnt++.
//    S_FORCE: l_req -> grant, stall=p_active, forced_cnt++ (saturating); S_IDLE, cnt=0.
//             !l_req -> S_IDLE, no grant.
//  - MAX_WAIT=1: S_IDLE with l_req & p_active goes directly to S_FORCE.
//  - Worst case: loader granted in cycle MAX_WAIT after its first blocked cycle.
//  - Grant cycle: mem_* driven from l_*; mem_read=!l_we, mem_write=l_we; p_rdata=0.
//    Non-grant cycle: mem_* driven from p_*; p_rdata=mem_read_data; stall=0.
//  - l_rdata/l_valid registered: read grant at N -> l_valid=1, l_rdata=mem_read_data at N+1.
//    A write grant gives no l_valid.
//  - stall=1 only in an S_FORCE grant with p_active. The pipeline replays its access next cycle.
//  - Reset (any state, including mid-wait): next state S_IDLE, wait_cnt=0, l_valid=0,
//    l_rdata=0, forced_cnt=0.
//    While reset=1: l_gnt=0, stall=0, mem_read=0, mem_write=0.
// TESTING
//  1. Pipe idle, loader write 0x10<-0xDEADBEEF, then loader read 0x10 -> l_gnt both cycles;
//     l_valid=1, l_rdata=0xDEADBEEF the cycle after the read.
//  2. MAX_WAIT=4, p_write held high, l_req rises at cycle 0 -> no grant cycles 0-3;
//     cycle 4 l_gnt=1, stall=1, mem_address=l_addr; forced_cnt=1.
//  3. p_active high cycles 0-1, low at cycle 2, l_req from cycle 0 -> l_gnt at cycle 2,
//     stall never 1, forced_cnt=0.
//  4. l_req dropped at cycle 2 in S_WAIT -> no grant, FSM returns to S_IDLE, wait_cnt=0.
//  5. Reset asserted during S_FORCE cycle -> l_gnt=0, mem_write=0; next cycle S_IDLE,
//     l_valid=0, forced_cnt=0.
//  6. Pipeline-only loads/stores, 100 cycles, l_req=0 -> mem_* equal p_* each cycle,
//     p_rdata=mem_read_data, stall=0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Purpose: arbitrates the single-port data memory between the pipeline MEM stage
//          (priority) and a loader/debug requester. A starvation FSM forces a loader
//          slot after MAX_WAIT blocked cycles by stalling the pipeline for one cycle.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   p_read/p_write/p_addr/p_wdata  MEM-stage access; p_rdata load data (comb)
//   stall                          pipeline must replay its access (comb)
//   l_req/l_we/l_addr/l_wdata      loader request, held until l_gnt
//   l_gnt                          loader access performed this cycle (comb)
//   l_rdata/l_valid                registered loader read data and 1-cycle valid
//   mem_*                          data_mem interface (asynchronous read)
//   forced_cnt                     saturating count of forced grants
module dmem_port_arbiter #(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned WORD_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p_read,
   input  logic              p_write,
   input  logic [WORD_W-1:0] p_addr,
   input  logic [WORD_W-1:0] p_wdata,
   output logic [WORD_W-1:0] p_rdata,
   output logic              stall,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [WORD_W-1:0] l_addr,
   input  logic [WORD_W-1:0] l_wdata,
   output logic              l_gnt,
   output logic [WORD_W-1:0] l_rdata,
   output logic              l_valid,
   output logic              mem_read,
   output logic              mem_write,
   output logic [WORD_W-1:0] mem_address,
   output logic [WORD_W-1:0] mem_write_data,
   input  logic [WORD_W-1:0] mem_read_data,
   output logic [CNT_W-1:0]  forced_cnt
);

   localparam int unsigned WCNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [WCNT_W-1:0]   r_wait_cnt;
   logic [WCNT_W-1:0]   w_next_cnt;
   logic                r_l_valid;
   logic [WORD_W-1:0]   r_l_rdata;
   logic [CNT_W-1:0]    r_forced_cnt;
   logic                w_p_active;
   logic                w_gnt;
   logic                w_force_gnt;
   logic                w_rd_gnt;

   assign w_p_active = p_read | p_write;
   assign w_rd_gnt   = w_gnt & ~l_we;

   // State register and loader read-data / forced-grant counters
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_wait_cnt   <= '0;
         r_l_valid    <= 1'b0;
         r_l_rdata    <= '0;
         r_forced_cnt <= '0;
      end else begin
         r_state    <= w_next_state;
         r_wait_cnt <= w_next_cnt;
         r_l_valid  <= w_rd_gnt;
         if (w_rd_gnt) begin
            r_l_rdata <= mem_read_data;
         end
         if (w_force_gnt && (r_forced_cnt != {CNT_W{1'b1}})) begin
            r_forced_cnt <= r_forced_cnt + CNT_W'(1);
         end
      end
   end

   // Next-state logic and grant decision
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_wait_cnt;
      w_gnt        = 1'b0;
      w_force_gnt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (l_req) begin
               if (!w_p_active) begin
                  w_gnt = 1'b1;
               end else if (MAX_WAIT == 1) begin
                  w_next_state = S_FORCE;
               end else begin
                  w_next_state = S_WAIT;
                  w_next_cnt   = WCNT_W'(1);
               end
            end
         end
         S_WAIT: begin
            if (!l_req) begin
               w_next_state = S_IDLE;
               w_next_cnt   = '0;
            end else if (!w_p_active) begin
               w_gnt        = 1'b1;
               w_next_state = S_IDLE;
               w_next_cnt   = '0;
            end else if (r_wait_cnt == WCNT_W'(MAX_WAIT - 1)) begin
               w_next_state = S_FORCE;
            end else begin
               w_next_cnt = r_wait_cnt + WCNT_W'(1);
            end
         end
         S_FORCE: begin
            w_next_state = S_IDLE;
            w_next_cnt   = '0;
            if (l_req) begin
               w_gnt       = 1'b1;
               w_force_gnt = 1'b1;
            end
         end
         default: begin
            w_next_state = S_IDLE;
            w_next_cnt   = '0;
         end
      endcase
      // No memory access may be granted while reset is held
      if (reset) begin
         w_gnt       = 1'b0;
         w_force_gnt = 1'b0;
      end
   end

   // Memory port steering: loader owns the port only in a grant cycle
   always_comb begin
      l_gnt          = w_gnt;
      stall          = w_force_gnt & w_p_active;
      mem_read       = p_read & ~reset;
      mem_write      = p_write & ~reset;
      mem_address    = p_addr;
      mem_write_data = p_wdata;
      p_rdata        = mem_read_data;
      if (w_gnt) begin
         mem_read       = ~l_we;
         mem_write      = l_we;
         mem_address    = l_addr;
         mem_write_data = l_wdata;
         p_rdata        = '0;
      end
   end

   assign l_valid    = r_l_valid;
   assign l_rdata    = r_l_rdata;
   assign forced_cnt = r_forced_cnt;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Purpose: directed, table-driven bench for dmem_port_arbiter (MAX_WAIT=4) with a
//          small asynchronous-read memory model behind the mem_* port.
module tb_dmem_port_arbiter;

   localparam logic [31:0] DB = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        reset;
   logic        p_read, p_write, l_req, l_we;
   logic [31:0] p_addr, p_wdata, l_addr, l_wdata;
   logic [31:0] p_rdata, l_rdata, mem_address, mem_write_data, mem_read_data;
   logic        stall, l_gnt, l_valid, mem_read, mem_write;
   logic [15:0] forced_cnt;

   logic [31:0] tb_mem [256];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        pr, pw;
      logic [31:0] pa, pwd;
      logic        lr, lwe;
      logic [31:0] la, lwd;
      logic        e_gnt, e_stall, e_mrd, e_mwr;
      logic [31:0] e_maddr;
      logic        e_lval;
      logic [31:0] e_lrd;
      logic [15:0] e_fcnt;
   } vec_t;

   vec_t vecs [23];

   always #5 clk = ~clk;

   dmem_port_arbiter #(.MAX_WAIT(4), .CNT_W(16), .WORD_W(32)) dut (
      .clk(clk), .reset(reset),
      .p_read(p_read), .p_write(p_write), .p_addr(p_addr), .p_wdata(p_wdata),
      .p_rdata(p_rdata), .stall(stall),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rdata(l_rdata), .l_valid(l_valid),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .forced_cnt(forced_cnt)
   );

   // Data memory model: asynchronous read, synchronous write
   assign mem_read_data = tb_mem[mem_address[7:0]];
   always @(posedge clk) begin
      if (mem_write) tb_mem[mem_address[7:0]] <= mem_write_data;
   end

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%h exp=%h", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic pr, pw, input logic [31:0] pa, pwd,
                               input logic lr, lwe, input logic [31:0] la, lwd,
                               input logic g, s, mr, mw, input logic [31:0] ma,
                               input logic lv, input logic [31:0] lrd, input logic [15:0] fc);
      vec_t v;
      v.pr = pr; v.pw = pw; v.pa = pa; v.pwd = pwd;
      v.lr = lr; v.lwe = lwe; v.la = la; v.lwd = lwd;
      v.e_gnt = g; v.e_stall = s; v.e_mrd = mr; v.e_mwr = mw; v.e_maddr = ma;
      v.e_lval = lv; v.e_lrd = lrd; v.e_fcnt = fc;
      return v;
   endfunction

   task automatic drive(input logic pr, pw, input logic [31:0] pa, pwd,
                        input logic lr, lwe, input logic [31:0] la, lwd);
      p_read = pr; p_write = pw; p_addr = pa; p_wdata = pwd;
      l_req = lr; l_we = lwe; l_addr = la; l_wdata = lwd;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] exp_prd;
      // loader write then read, pipe idle
      vecs[0]  = mk(0,0,32'h20,0,   1,1,32'h10,DB,    1,0,0,1,32'h10, 0,32'h0,0);
      vecs[1]  = mk(0,0,32'h20,0,   1,0,32'h10,0,     1,0,1,0,32'h10, 0,32'h0,0);
      vecs[2]  = mk(0,0,32'h20,0,   0,0,32'h0,0,      0,0,0,0,32'h20, 1,DB,0);
      // pipeline store held: four blocked cycles then forced grant
      for (int i = 3; i <= 6; i++)
         vecs[i] = mk(0,1,32'h40,32'h11, 1,1,32'h80,32'h55, 0,0,0,1,32'h40, 0,DB,0);
      vecs[7]  = mk(0,1,32'h40,32'h11, 1,1,32'h80,32'h55, 1,1,0,1,32'h80, 0,DB,0);
      vecs[8]  = mk(0,0,32'h44,0,   0,0,32'h0,0,      0,0,0,0,32'h44, 0,DB,1);
      // pipe active two cycles then idles: normal grant, no stall
      vecs[9]  = mk(1,0,32'h48,0,   1,0,32'h10,0,     0,0,1,0,32'h48, 0,DB,1);
      vecs[10] = mk(1,0,32'h48,0,   1,0,32'h10,0,     0,0,1,0,32'h48, 0,DB,1);
      vecs[11] = mk(0,0,32'h4C,0,   1,0,32'h10,0,     1,0,1,0,32'h10, 0,DB,1);
      vecs[12] = mk(0,0,32'h4C,0,   0,0,32'h0,0,      0,0,0,0,32'h4C, 1,DB,1);
      // request dropped mid-wait; re-request must wait the full window again
      vecs[13] = mk(1,0,32'h50,0,   1,1,32'h84,32'h66, 0,0,1,0,32'h50, 0,DB,1);
      vecs[14] = mk(1,0,32'h50,0,   1,1,32'h84,32'h66, 0,0,1,0,32'h50, 0,DB,1);
      vecs[15] = mk(1,0,32'h50,0,   0,1,32'h84,32'h66, 0,0,1,0,32'h50, 0,DB,1);
      for (int i = 16; i <= 19; i++)
         vecs[i] = mk(1,0,32'h50,0, 1,1,32'h84,32'h66, 0,0,1,0,32'h50, 0,DB,1);
      vecs[20] = mk(1,0,32'h50,0,   1,1,32'h84,32'h66, 1,1,0,1,32'h84, 0,DB,1);
      vecs[21] = mk(0,0,32'h54,0,   0,0,32'h0,0,      0,0,0,0,32'h54, 0,DB,2);
      // read and write together pass through unchanged
      vecs[22] = mk(1,1,32'h58,32'h77, 0,0,32'h0,0,   0,0,1,1,32'h58, 0,DB,2);

      // reset with all requests active: nothing may reach memory
      reset = 1'b1;
      drive(1,1,32'h30,32'h99, 1,1,32'h34,32'h98);
      next_cycle();
      @(negedge clk);
      chk("rst_gnt",   0, 32'(l_gnt), 0);
      chk("rst_stall", 0, 32'(stall), 0);
      chk("rst_mrd",   0, 32'(mem_read), 0);
      chk("rst_mwr",   0, 32'(mem_write), 0);
      next_cycle();
      reset = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].pr, vecs[i].pw, vecs[i].pa, vecs[i].pwd,
               vecs[i].lr, vecs[i].lwe, vecs[i].la, vecs[i].lwd);
         @(negedge clk);
         exp_prd = vecs[i].e_gnt ? 32'h0 : tb_mem[vecs[i].pa[7:0]];
         chk("gnt",   i, 32'(l_gnt),     32'(vecs[i].e_gnt));
         chk("stall", i, 32'(stall),     32'(vecs[i].e_stall));
         chk("mrd",   i, 32'(mem_read),  32'(vecs[i].e_mrd));
         chk("mwr",   i, 32'(mem_write), 32'(vecs[i].e_mwr));
         chk("maddr", i, mem_address,    vecs[i].e_maddr);
         chk("mwdat", i, mem_write_data, vecs[i].e_gnt ? vecs[i].lwd : vecs[i].pwd);
         chk("prd",   i, p_rdata,        exp_prd);
         chk("lval",  i, 32'(l_valid),   32'(vecs[i].e_lval));
         chk("lrd",   i, l_rdata,        vecs[i].e_lrd);
         chk("fcnt",  i, 32'(forced_cnt), 32'(vecs[i].e_fcnt));
         next_cycle();
      end

      // reset landing on the forced-grant cycle
      for (int i = 0; i < 4; i++) begin
         drive(0,1,32'h60,32'h1, 1,1,32'h88,32'h2);
         @(negedge clk);
         chk("f_wait_gnt", i, 32'(l_gnt), 0);
         next_cycle();
      end
      reset = 1'b1;
      @(negedge clk);
      chk("f_rst_gnt",   0, 32'(l_gnt), 0);
      chk("f_rst_mwr",   0, 32'(mem_write), 0);
      chk("f_rst_stall", 0, 32'(stall), 0);
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      chk("f_post_lval", 0, 32'(l_valid), 0);
      chk("f_post_fcnt", 0, 32'(forced_cnt), 0);
      chk("f_post_lrd",  0, l_rdata, 0);
      chk("f_post_gnt",  0, 32'(l_gnt), 0);
      next_cycle();
      drive(0,0,32'h0,0, 0,0,32'h0,0);
      next_cycle();

      // pipeline-only traffic passes straight through
      for (int i = 0; i < 100; i++) begin
         drive(1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
               $urandom & 32'h0000_00FC, $urandom, 0, 1'($urandom_range(0,1)), $urandom, $urandom);
         @(negedge clk);
         chk("pass_ctl", i, {29'h0, mem_read, mem_write, stall}, {29'h0, p_read, p_write, 1'b0});
         chk("pass_addr", i, mem_address, p_addr);
         chk("pass_wdat", i, mem_write_data, p_wdata);
         chk("pass_prd", i, p_rdata, tb_mem[p_addr[7:0]]);
         chk("pass_gnt", i, 32'(l_gnt), 0);
         next_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
